// File: rtl/lsu_req_seq.sv
// Load/store request sequencer: splits misaligned and capability accesses into two bus
// transactions and owns the response-side state. Optional error counter: LSU_REQ_SEQ_ERR_CNT_EN.
`timescale 1ns/1ps
module lsu_req_seq #(
  parameter bit          CHERIoTEn = 1'b1,
  parameter int unsigned ErrCntW   = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               cheri_pmode_i,
  input  logic               lsu_req_i,
  input  logic               lsu_we_i,
  input  logic [1:0]         lsu_type_i,
  input  logic               lsu_sign_ext_i,
  input  logic               lsu_is_cap_i,
  input  logic [31:0]        lsu_addr_i,
  input  logic [32:0]        lsu_wdata_i,
  input  logic [32:0]        lsu_wcap_msw_i,
  output logic               lsu_busy_o,
  output logic               lsu_resp_valid_o,
  output logic               lsu_resp_err_o,
  output logic               data_req_o,
  input  logic               data_gnt_i,
  output logic [31:0]        data_addr_o,
  output logic               data_we_o,
  output logic [3:0]         data_be_o,
  output logic [32:0]        data_wdata_o,
  input  logic               data_rvalid_i,
  input  logic               data_err_i,
  input  logic [32:0]        data_rdata_i,
`ifdef LSU_REQ_SEQ_ERR_CNT_EN
  output logic [ErrCntW-1:0] err_cnt_o,
`endif
  output logic [23:0]        rdata_q,
  output logic [1:0]         rdata_offset_q,
  output logic [1:0]         data_type_q,
  output logic               data_sign_ext_q,
  output logic               data_we_q,
  output logic               lsu_err_q,
  output logic               cheri_err_q,
  output logic               resp_is_cap_q,
  output logic [1:0]         cap_rx_fsm_q,
  output logic [32:0]        cap_lsw_q,
  output logic               cap_lsw_err_q
);

  typedef enum logic [2:0] {IDLE, GNT1, RESP1, GNT2, RESP2} state_e;

  localparam logic [1:0] CRX_IDLE       = 2'b00;
  localparam logic [1:0] CRX_WAIT_RESP1 = 2'b01;
  localparam logic [1:0] CRX_WAIT_RESP2 = 2'b10;

  state_e      state_q;
  logic [31:2] addr_q;
  logic [32:0] wdata_q;
  logic [32:0] wmsw_q;
  logic        cheri_resp_q;

  logic        is_cap_req;
  logic        split;
  logic        in_second;
  logic [31:0] addr_first;
  logic [31:0] addr_second;
  logic [7:0]  word_be;
  logic [7:0]  half_be;
  logic [3:0]  byte_be;
  logic [3:0]  be_first;
  logic [3:0]  be_second;
  logic [63:0] wdata_dbl;

  assign is_cap_req = lsu_is_cap_i & CHERIoTEn & cheri_pmode_i;

  assign split = resp_is_cap_q
               | ((data_type_q == 2'b00) && (rdata_offset_q != 2'b00))
               | ((data_type_q == 2'b01) && (rdata_offset_q == 2'b11));

  assign in_second   = (state_q == GNT2) || (state_q == RESP2);
  assign addr_first  = resp_is_cap_q ? {addr_q[31:3], 3'b000} : {addr_q[31:2], 2'b00};
  assign addr_second = addr_first + 32'd4;

  // Shifting into a double-width mask yields both halves: low nibble first word, high nibble second.
  assign word_be = 8'h0F << rdata_offset_q;
  assign half_be = 8'h03 << rdata_offset_q;
  assign byte_be = 4'b0001 << rdata_offset_q;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    be_first  = 4'h0;
    be_second = 4'h0;
    if (resp_is_cap_q) begin
      be_first  = 4'hF;
      be_second = 4'hF;
    end else begin
      case (data_type_q)
        2'b00: begin
          be_first  = word_be[3:0];
          be_second = word_be[7:4];
        end
        2'b01: begin
          be_first  = half_be[3:0];
          be_second = half_be[7:4];
        end
        default: be_first = byte_be;
      endcase
    end
  end

  assign wdata_dbl = {wdata_q[31:0], wdata_q[31:0]} << {rdata_offset_q, 3'b000};

  assign data_req_o   = (state_q == GNT1) || (state_q == GNT2);
  assign lsu_busy_o   = (state_q != IDLE);
  assign data_we_o    = data_req_o & data_we_q;
  assign data_addr_o  = !data_req_o ? 32'h0 : (in_second ? addr_second : addr_first);
  assign data_be_o    = !data_req_o ? 4'h0  : (in_second ? be_second : be_first);
  assign data_wdata_o = !data_req_o    ? 33'h0 :
                        resp_is_cap_q  ? (in_second ? wmsw_q : wdata_q) :
                                         {1'b0, wdata_dbl[63:32]};

  assign lsu_resp_valid_o = cheri_resp_q
                          | (data_rvalid_i & (((state_q == RESP1) & ~split) | (state_q == RESP2)));
  assign lsu_resp_err_o   = lsu_resp_valid_o & (data_err_i | lsu_err_q | cheri_err_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      wdata_q         <= '0;
      wmsw_q          <= '0;
      cheri_resp_q    <= 1'b0;
      rdata_q         <= '0;
      rdata_offset_q  <= '0;
      data_type_q     <= '0;
      data_sign_ext_q <= 1'b0;
      data_we_q       <= 1'b0;
      lsu_err_q       <= 1'b0;
      cheri_err_q     <= 1'b0;
      resp_is_cap_q   <= 1'b0;
      cap_rx_fsm_q    <= CRX_IDLE;
      cap_lsw_q       <= '0;
      cap_lsw_err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      cheri_resp_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (lsu_req_i) begin
            addr_q          <= lsu_addr_i[31:2];
            rdata_offset_q  <= lsu_addr_i[1:0];
            data_type_q     <= lsu_type_i;
            data_sign_ext_q <= lsu_sign_ext_i;
            data_we_q       <= lsu_we_i;
            wdata_q         <= lsu_wdata_i;
            wmsw_q          <= lsu_wcap_msw_i;
            resp_is_cap_q   <= is_cap_req;
            lsu_err_q       <= 1'b0;
            cap_lsw_err_q   <= 1'b0;
            if (is_cap_req && (lsu_addr_i[2:0] != 3'b000)) begin
              // Misaligned capability: answer with an error without touching the bus.
              cheri_err_q  <= 1'b1;
              cheri_resp_q <= 1'b1;
            end else begin
              cheri_err_q <= 1'b0;
              state_q     <= GNT1;
              if (is_cap_req) cap_rx_fsm_q <= CRX_WAIT_RESP1;
            end
          end
        end
        GNT1: if (data_gnt_i) state_q <= RESP1;
        RESP1: begin
          if (data_rvalid_i) begin
            if (split) begin
              state_q   <= GNT2;
              lsu_err_q <= data_err_i;
              if (resp_is_cap_q) begin
                cap_lsw_q     <= data_rdata_i;
                cap_lsw_err_q <= data_err_i;
                cap_rx_fsm_q  <= CRX_WAIT_RESP2;
              end else begin
                rdata_q <= data_rdata_i[31:8];
              end
            end else begin
              state_q <= IDLE;
            end
          end
        end
        GNT2: if (data_gnt_i) state_q <= RESP2;
        RESP2: begin
          if (data_rvalid_i) begin
            state_q <= IDLE;
            if (resp_is_cap_q) cap_rx_fsm_q <= CRX_IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef LSU_REQ_SEQ_ERR_CNT_EN
  logic [ErrCntW-1:0] err_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_cnt_q <= '0;
    end else if (lsu_resp_valid_o && lsu_resp_err_o && !(&err_cnt_q)) begin
      err_cnt_q <= err_cnt_q + {{(ErrCntW-1){1'b0}}, 1'b1};
    end
  end

  assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_lsu_req_seq.sv
// Self-checking bench for lsu_req_seq: directed scenarios plus randomized accesses checked
// against a byte-level reference model of the bus transactions.
`timescale 1ns/1ps
module tb_lsu_req_seq;

  logic        clk_i, rst_ni;
  logic        cheri_pmode_i, lsu_req_i, lsu_we_i, lsu_sign_ext_i, lsu_is_cap_i;
  logic [1:0]  lsu_type_i;
  logic [31:0] lsu_addr_i;
  logic [32:0] lsu_wdata_i, lsu_wcap_msw_i;
  logic        lsu_busy_o, lsu_resp_valid_o, lsu_resp_err_o;
  logic        data_req_o, data_gnt_i, data_we_o, data_rvalid_i, data_err_i;
  logic [31:0] data_addr_o;
  logic [3:0]  data_be_o;
  logic [32:0] data_wdata_o, data_rdata_i;
  logic [23:0] rdata_q;
  logic [1:0]  rdata_offset_q, data_type_q, cap_rx_fsm_q;
  logic        data_sign_ext_q, data_we_q, lsu_err_q, cheri_err_q, resp_is_cap_q, cap_lsw_err_q;
  logic [32:0] cap_lsw_q;
`ifdef LSU_REQ_SEQ_ERR_CNT_EN
  logic [15:0] err_cnt_o;
`endif

  lsu_req_seq dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .cheri_pmode_i(cheri_pmode_i),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_type_i(lsu_type_i),
    .lsu_sign_ext_i(lsu_sign_ext_i), .lsu_is_cap_i(lsu_is_cap_i), .lsu_addr_i(lsu_addr_i),
    .lsu_wdata_i(lsu_wdata_i), .lsu_wcap_msw_i(lsu_wcap_msw_i),
    .lsu_busy_o(lsu_busy_o), .lsu_resp_valid_o(lsu_resp_valid_o), .lsu_resp_err_o(lsu_resp_err_o),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_addr_o(data_addr_o),
    .data_we_o(data_we_o), .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
    .data_rvalid_i(data_rvalid_i), .data_err_i(data_err_i), .data_rdata_i(data_rdata_i),
`ifdef LSU_REQ_SEQ_ERR_CNT_EN
    .err_cnt_o(err_cnt_o),
`endif
    .rdata_q(rdata_q), .rdata_offset_q(rdata_offset_q), .data_type_q(data_type_q),
    .data_sign_ext_q(data_sign_ext_q), .data_we_q(data_we_q), .lsu_err_q(lsu_err_q),
    .cheri_err_q(cheri_err_q), .resp_is_cap_q(resp_is_cap_q), .cap_rx_fsm_q(cap_rx_fsm_q),
    .cap_lsw_q(cap_lsw_q), .cap_lsw_err_q(cap_lsw_err_q)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  logic [142:0] all_outs;
  assign all_outs = {lsu_busy_o, lsu_resp_valid_o, lsu_resp_err_o, data_req_o, data_addr_o,
                     data_we_o, data_be_o, data_wdata_o, rdata_q, rdata_offset_q, data_type_q,
                     data_sign_ext_q, data_we_q, lsu_err_q, cheri_err_q, resp_is_cap_q,
                     cap_rx_fsm_q, cap_lsw_q, cap_lsw_err_q};

  // Observations gathered by the bus responder for one access
  int          obs_n, resp_cnt, resp_txn, resp_cyc, trace_n;
  logic        resp_err;
  logic [31:0] obs_addr [4];
  logic [3:0]  obs_be   [4];
  logic [32:0] obs_wd   [4];
  logic        obs_we   [4];
  logic [1:0]  trace    [8];

  // Reference model expectations
  int          exp_n;
  bit          exp_cheri;
  logic [31:0] exp_addr [2];
  logic [3:0]  exp_be   [2];
  logic [32:0] exp_wd   [2];

  task automatic model_access(input logic [31:0] a, input logic [1:0] t, input bit cap_eff,
                              input logic [32:0] wd, input logic [32:0] msw);
    int size, o;
    logic [31:0] base, rot;
    exp_cheri = 1'b0;
    for (int k = 0; k < 2; k++) begin
      exp_addr[k] = '0; exp_be[k] = '0; exp_wd[k] = '0;
    end
    if (cap_eff) begin
      if (a[2:0] != 3'd0) begin
        exp_n = 0; exp_cheri = 1'b1;
      end else begin
        exp_n = 2;
        exp_addr[0] = a; exp_addr[1] = a + 32'd4;
        exp_be[0] = 4'hF; exp_be[1] = 4'hF;
        exp_wd[0] = wd; exp_wd[1] = msw;
      end
    end else begin
      size = (t == 2'b00) ? 4 : (t == 2'b01) ? 2 : 1;
      o    = int'(a[1:0]);
      base = {a[31:2], 2'b00};
      exp_n = (o + size > 4) ? 2 : 1;
      for (int i = 0; i < size; i++) exp_be[(o + i) / 4][(o + i) % 4] = 1'b1;
      for (int l = 0; l < 4; l++) rot[8*l +: 8] = wd[8*((l - o + 4) % 4) +: 8];
      for (int k = 0; k < exp_n; k++) begin
        exp_addr[k] = base + 32'(4 * k);
        exp_wd[k]   = {1'b0, rot};
      end
    end
  endtask

  // Issues one request and plays the bus slave until the sequencer is idle again.
  task automatic bus_access(input logic [31:0] a, input logic [1:0] t, input logic we,
                            input logic se, input logic cap, input logic pmode,
                            input logic [32:0] wd, input logic [32:0] msw,
                            input logic [32:0] rd0, input logic [32:0] rd1,
                            input logic e0, input logic e1, input bit rand_lat);
    int  phase, dly;
    bit  done, busy_now;
    obs_n = 0; resp_cnt = 0; resp_err = 1'b0; resp_txn = -1; resp_cyc = -1; trace_n = 0;
    @(negedge clk_i);
    lsu_req_i = 1'b1; lsu_addr_i = a; lsu_type_i = t; lsu_we_i = we; lsu_sign_ext_i = se;
    lsu_is_cap_i = cap; cheri_pmode_i = pmode; lsu_wdata_i = wd; lsu_wcap_msw_i = msw;
    @(negedge clk_i);
    lsu_req_i = 1'b0; lsu_addr_i = $urandom; lsu_type_i = 2'($urandom); lsu_we_i = 1'($urandom);
    lsu_sign_ext_i = 1'($urandom); lsu_is_cap_i = 1'($urandom);
    lsu_wdata_i = {1'($urandom), $urandom}; lsu_wcap_msw_i = {1'($urandom), $urandom};
    phase = 0; dly = 0; done = 1'b0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_err_i = 1'b0;
      data_rdata_i = {1'($urandom), $urandom};
      #1;
      busy_now = lsu_busy_o;
      if (trace_n == 0) begin
        trace[0] = cap_rx_fsm_q; trace_n = 1;
      end else if (trace[trace_n-1] != cap_rx_fsm_q && trace_n < 8) begin
        trace[trace_n] = cap_rx_fsm_q; trace_n++;
      end
      if (phase == 2) begin
        if (dly == 0) begin
          data_rvalid_i = 1'b1;
          data_rdata_i  = (obs_n == 1) ? rd0 : rd1;
          data_err_i    = (obs_n == 1) ? e0 : e1;
          phase = 0;
        end else dly--;
      end else if (data_req_o) begin
        if (phase == 0) begin
          if (obs_n < 4) begin
            obs_addr[obs_n] = data_addr_o; obs_be[obs_n] = data_be_o;
            obs_wd[obs_n] = data_wdata_o; obs_we[obs_n] = data_we_o;
          end
          obs_n++;
          phase = 1;
          dly = rand_lat ? int'($urandom_range(0, 2)) : 0;
        end
        if (dly == 0) begin
          data_gnt_i = 1'b1; phase = 2;
          dly = rand_lat ? int'($urandom_range(0, 2)) : 0;
        end else dly--;
      end
      #1;
      if (lsu_resp_valid_o) begin
        resp_cnt++; resp_err = lsu_resp_err_o;
        resp_txn = data_rvalid_i ? obs_n : 0; resp_cyc = cyc;
      end
      if (!busy_now) done = 1'b1;
      else @(negedge clk_i);
    end
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_err_i = 1'b0;
    n_checks++;
    if (!done) $display("FAIL access_timeout addr=%h: sequencer still busy after 40 cycles", a);
    else n_pass++;
  endtask

  task automatic test_reset;
    rst_ni = 1'b0;
    #23;
    n_checks++; if (all_outs !== '0) $display("FAIL reset_outputs got %h exp 0", all_outs); else n_pass++;
    @(negedge clk_i); rst_ni = 1'b1;
    #1;
    n_checks++; if (all_outs !== '0) $display("FAIL after_reset_outputs got %h exp 0", all_outs); else n_pass++;
  endtask

  task automatic test_aligned_lw;
    bus_access(32'h100, 2'b00, 0, 0, 0, 1, 33'h0_0BADF00D, 33'h0, 33'h0_DEADBEEF, 33'h0, 0, 0, 0);
    n_checks++; if (obs_n !== 1) $display("FAIL lw_ntx got %0d exp 1", obs_n); else n_pass++;
    n_checks++; if (obs_addr[0] !== 32'h100) $display("FAIL lw_addr got %h exp 100", obs_addr[0]); else n_pass++;
    n_checks++; if (obs_be[0] !== 4'hF) $display("FAIL lw_be got %h exp f", obs_be[0]); else n_pass++;
    n_checks++; if (obs_we[0] !== 1'b0) $display("FAIL lw_we got %b exp 0", obs_we[0]); else n_pass++;
    n_checks++; if (resp_cnt !== 1 || resp_txn !== 1) $display("FAIL lw_resp got cnt=%0d txn=%0d exp 1/1", resp_cnt, resp_txn); else n_pass++;
    n_checks++; if (resp_err !== 1'b0) $display("FAIL lw_err got %b exp 0", resp_err); else n_pass++;
  endtask

  task automatic test_misaligned_lw;
    bus_access(32'h103, 2'b00, 0, 0, 0, 1, 33'h0, 33'h0, 33'h0_AABBCCDD, 33'h0_11223344, 0, 0, 0);
    n_checks++; if (obs_n !== 2) $display("FAIL mlw_ntx got %0d exp 2", obs_n); else n_pass++;
    n_checks++; if (obs_addr[0] !== 32'h100 || obs_be[0] !== 4'h8) $display("FAIL mlw_first got %h/%h exp 100/8", obs_addr[0], obs_be[0]); else n_pass++;
    n_checks++; if (obs_addr[1] !== 32'h104 || obs_be[1] !== 4'h7) $display("FAIL mlw_second got %h/%h exp 104/7", obs_addr[1], obs_be[1]); else n_pass++;
    n_checks++; if (rdata_q !== 24'hAABBCC) $display("FAIL mlw_rdata_q got %h exp aabbcc", rdata_q); else n_pass++;
    n_checks++; if (rdata_offset_q !== 2'd3) $display("FAIL mlw_offset got %0d exp 3", rdata_offset_q); else n_pass++;
    n_checks++; if (resp_cnt !== 1 || resp_txn !== 2) $display("FAIL mlw_resp got cnt=%0d txn=%0d exp 1/2", resp_cnt, resp_txn); else n_pass++;
  endtask

  task automatic test_cap_load_err;
    bus_access(32'h208, 2'b00, 0, 0, 1, 1, 33'h0, 33'h0, 33'h1_CAFE0001, 33'h0_CAFE0002, 1, 0, 0);
    n_checks++; if (obs_n !== 2) $display("FAIL cap_ntx got %0d exp 2", obs_n); else n_pass++;
    n_checks++; if (obs_addr[0] !== 32'h208 || obs_addr[1] !== 32'h20C) $display("FAIL cap_addr got %h/%h exp 208/20c", obs_addr[0], obs_addr[1]); else n_pass++;
    n_checks++; if (obs_be[0] !== 4'hF || obs_be[1] !== 4'hF) $display("FAIL cap_be got %h/%h exp f/f", obs_be[0], obs_be[1]); else n_pass++;
    n_checks++; if (trace_n !== 3 || {trace[0], trace[1], trace[2]} !== 6'b01_10_00) $display("FAIL cap_fsm_trace got n=%0d %0d,%0d,%0d exp 1,2,0", trace_n, trace[0], trace[1], trace[2]); else n_pass++;
    n_checks++; if (cap_lsw_err_q !== 1'b1 || cap_lsw_q !== 33'h1_CAFE0001) $display("FAIL cap_lsw got %b/%h exp 1/1cafe0001", cap_lsw_err_q, cap_lsw_q); else n_pass++;
    n_checks++; if (resp_cnt !== 1 || resp_err !== 1'b1) $display("FAIL cap_resp got cnt=%0d err=%b exp 1/1", resp_cnt, resp_err); else n_pass++;
  endtask

  task automatic test_cap_misaligned;
    bus_access(32'h20C, 2'b00, 0, 0, 1, 1, 33'h0, 33'h0, 33'h0, 33'h0, 0, 0, 0);
    n_checks++; if (obs_n !== 0) $display("FAIL capmis_ntx got %0d exp 0", obs_n); else n_pass++;
    n_checks++; if (cheri_err_q !== 1'b1) $display("FAIL capmis_cheri_err got %b exp 1", cheri_err_q); else n_pass++;
    n_checks++; if (resp_cnt !== 1 || resp_err !== 1'b1 || resp_cyc !== 0) $display("FAIL capmis_resp got cnt=%0d err=%b cyc=%0d exp 1/1/0", resp_cnt, resp_err, resp_cyc); else n_pass++;
    bus_access(32'h20C, 2'b00, 0, 0, 1, 0, 33'h0, 33'h0, 33'h0_12345678, 33'h0, 0, 0, 0);
    n_checks++; if (obs_n !== 1 || obs_addr[0] !== 32'h20C || obs_be[0] !== 4'hF) $display("FAIL cap_nopmode got n=%0d %h/%h exp 1 20c/f", obs_n, obs_addr[0], obs_be[0]); else n_pass++;
    n_checks++; if (resp_is_cap_q !== 1'b0 || cheri_err_q !== 1'b0 || resp_err !== 1'b0) $display("FAIL cap_nopmode_flags got %b%b%b exp 000", resp_is_cap_q, cheri_err_q, resp_err); else n_pass++;
  endtask

  task automatic test_store_wrap;
    bus_access(32'hFFFF_FFFE, 2'b00, 1, 0, 0, 1, 33'h0_11223344, 33'h0, 33'h0, 33'h0, 0, 0, 0);
    n_checks++; if (obs_n !== 2) $display("FAIL sw_ntx got %0d exp 2", obs_n); else n_pass++;
    n_checks++; if (obs_addr[0] !== 32'hFFFF_FFFC || obs_be[0] !== 4'hC) $display("FAIL sw_first got %h/%h exp fffffffc/c", obs_addr[0], obs_be[0]); else n_pass++;
    n_checks++; if (obs_addr[1] !== 32'h0 || obs_be[1] !== 4'h3) $display("FAIL sw_second got %h/%h exp 0/3", obs_addr[1], obs_be[1]); else n_pass++;
    n_checks++; if (obs_wd[0] !== 33'h0_33441122 || obs_wd[1] !== 33'h0_33441122) $display("FAIL sw_wdata got %h/%h exp 033441122", obs_wd[0], obs_wd[1]); else n_pass++;
    n_checks++; if (obs_we[0] !== 1'b1 || obs_we[1] !== 1'b1) $display("FAIL sw_we got %b/%b exp 1/1", obs_we[0], obs_we[1]); else n_pass++;
  endtask

  task automatic test_reset_mid;
    @(negedge clk_i);
    lsu_req_i = 1'b1; lsu_addr_i = 32'h300; lsu_type_i = 2'b00; lsu_is_cap_i = 1'b1;
    cheri_pmode_i = 1'b1; lsu_we_i = 1'b0;
    @(negedge clk_i);
    lsu_req_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++; if (data_req_o !== 1'b1) $display("FAIL rstmid_req%0d got %b exp 1", i, data_req_o); else n_pass++;
      data_gnt_i = 1'b1;
      @(negedge clk_i);
      data_gnt_i = 1'b0;
      if (i == 0) begin
        data_rvalid_i = 1'b1; data_rdata_i = 33'h0_55AA55AA;
        @(negedge clk_i);
        data_rvalid_i = 1'b0;
      end
    end
    #1;
    n_checks++; if ({lsu_busy_o, cap_rx_fsm_q} !== 3'b110) $display("FAIL rstmid_in_resp2 got %b exp 110", {lsu_busy_o, cap_rx_fsm_q}); else n_pass++;
    rst_ni = 1'b0;
    #1;
    n_checks++; if (all_outs !== '0) $display("FAIL rstmid_outputs got %h exp 0", all_outs); else n_pass++;
    @(negedge clk_i); rst_ni = 1'b1;
    @(negedge clk_i);
    data_rvalid_i = 1'b1; data_err_i = 1'b1;
    #1;
    n_checks++; if ({lsu_resp_valid_o, lsu_resp_err_o, lsu_busy_o} !== 3'b000) $display("FAIL rstmid_late_rvalid got %b exp 000", {lsu_resp_valid_o, lsu_resp_err_o, lsu_busy_o}); else n_pass++;
    @(negedge clk_i);
    data_rvalid_i = 1'b0; data_err_i = 1'b0;
  endtask

  task automatic test_random;
    logic [31:0] a;
    logic [1:0]  t;
    logic        we, se, cap, pmode, e0, e1;
    bit          cap_eff, exp_err;
    logic [32:0] wd, msw, rd0, rd1;
    logic [23:0] m_rdata;
    logic [32:0] m_cap_lsw;
    logic        m_cap_lsw_err, m_lsu_err;
    @(negedge clk_i); rst_ni = 1'b0;
    #2 rst_ni = 1'b1;
    m_rdata = '0; m_cap_lsw = '0;
    for (int it = 0; it < 150; it++) begin
      a = $urandom; t = 2'($urandom); we = 1'($urandom); se = 1'($urandom);
      cap = 1'($urandom); pmode = 1'($urandom); e0 = 1'($urandom); e1 = 1'($urandom);
      wd = {1'($urandom), $urandom}; msw = {1'($urandom), $urandom};
      rd0 = {1'($urandom), $urandom}; rd1 = {1'($urandom), $urandom};
      if ($urandom_range(0, 3) == 0) a[31:4] = '1;
      cap_eff = cap & pmode;
      if (cap_eff && $urandom_range(0, 1) == 1) a[2:0] = 3'b000;
      model_access(a, t, cap_eff, wd, msw);
      bus_access(a, t, we, se, cap, pmode, wd, msw, rd0, rd1, e0, e1, 1);
      exp_err = exp_cheri ? 1'b1 : (exp_n == 1) ? e0 : (e0 | e1);
      m_lsu_err = (exp_n == 2) ? e0 : 1'b0;
      m_cap_lsw_err = 1'b0;
      if (cap_eff && !exp_cheri) begin
        m_cap_lsw = rd0; m_cap_lsw_err = e0;
      end else if (exp_n == 2) begin
        m_rdata = rd0[31:8];
      end
      n_checks++; if (obs_n !== exp_n) $display("FAIL rnd_ntx it=%0d addr=%h got %0d exp %0d", it, a, obs_n, exp_n); else n_pass++;
      for (int k = 0; k < exp_n; k++) begin
        n_checks++;
        if (obs_addr[k] !== exp_addr[k] || obs_be[k] !== exp_be[k] || obs_wd[k] !== exp_wd[k] || obs_we[k] !== we)
          $display("FAIL rnd_txn%0d it=%0d got %h/%h/%h/%b exp %h/%h/%h/%b", k, it,
                   obs_addr[k], obs_be[k], obs_wd[k], obs_we[k], exp_addr[k], exp_be[k], exp_wd[k], we);
        else n_pass++;
      end
      n_checks++; if (resp_cnt !== 1 || resp_txn !== exp_n || resp_err !== exp_err) $display("FAIL rnd_resp it=%0d got cnt=%0d txn=%0d err=%b exp 1/%0d/%b", it, resp_cnt, resp_txn, resp_err, exp_n, exp_err); else n_pass++;
      n_checks++; if ({rdata_offset_q, data_type_q, data_sign_ext_q, data_we_q, resp_is_cap_q} !== {a[1:0], t, se, we, cap_eff}) $display("FAIL rnd_regs it=%0d got %b exp %b", it, {rdata_offset_q, data_type_q, data_sign_ext_q, data_we_q, resp_is_cap_q}, {a[1:0], t, se, we, cap_eff}); else n_pass++;
      n_checks++; if ({lsu_err_q, cheri_err_q, cap_lsw_err_q, cap_rx_fsm_q, lsu_busy_o} !== {m_lsu_err, exp_cheri, m_cap_lsw_err, 2'b00, 1'b0}) $display("FAIL rnd_flags it=%0d got %b exp %b", it, {lsu_err_q, cheri_err_q, cap_lsw_err_q, cap_rx_fsm_q, lsu_busy_o}, {m_lsu_err, exp_cheri, m_cap_lsw_err, 2'b00, 1'b0}); else n_pass++;
      n_checks++; if (rdata_q !== m_rdata || cap_lsw_q !== m_cap_lsw) $display("FAIL rnd_data it=%0d got %h/%h exp %h/%h", it, rdata_q, cap_lsw_q, m_rdata, m_cap_lsw); else n_pass++;
    end
  endtask

  initial begin
    rst_ni = 1'b0; cheri_pmode_i = 1'b0; lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_type_i = '0;
    lsu_sign_ext_i = 1'b0; lsu_is_cap_i = 1'b0; lsu_addr_i = '0; lsu_wdata_i = '0;
    lsu_wcap_msw_i = '0; data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_err_i = 1'b0;
    data_rdata_i = '0;
    test_reset;
    test_aligned_lw;
    test_misaligned_lw;
    test_cap_load_err;
    test_cap_misaligned;
    test_store_wrap;
    test_reset_mid;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "global timeout");
  end

endmodule
